dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares the single data-memory port between the stack core (load/store via T) and a host loader/debug port.
- Sequences every access as a three-phase transaction: arbitrate, hold request until memory ready, complete.
- Stalls the core while its access is outstanding.
- Sits between the core's memory-access signals and the dm block; the memory side uses a req/ready handshake so wait states are tolerated.

Parameters:
AW, 16, address width (byte address, matches PC/T width)
DW, 16, data width
RR_INIT, 1, initial last_owner after reset (1 = host, so the core wins the first contended grant)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset, synchronous, active-high
core_req  in  1  core access request; held stable while core_stall=1
core_we  in  1  1=store, 0=load
core_addr  in  AW  core address (T)
core_wdata  in  DW  store data
core_rdata  out  DW  load data, registered
core_stall  out  1  core must freeze PC/stack writes
host_req  in  1  host request; held stable until host_ack
host_we  in  1  host write enable
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_rdata  out  DW  host read data, registered
host_ack  out  1  one-cycle completion pulse
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid when mem_ready=1
mem_ready  in  1  memory completion; meaningful only while mem_req=1

Behaviour:
- Reset, evaluated at a rising edge with Rst=1:
  - state=IDLE, owner=0, last_owner=RR_INIT.
  - mem_req/mem_we=0; mem_addr/mem_wdata=0.
  - core_rdata=0, host_rdata=0, host_ack=0.
  - Reset mid-transaction abandons the access; mem_req is low from the first cycle after the reset edge.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Neither request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both requests: grant the one that is not last_owner (round-robin).
  - On grant: latch we/addr/wdata from the granted port into holding registers, set owner, set last_owner=owner, go to BUSY.
- BUSY:
  - mem_req=1; mem_we/mem_addr/mem_wdata driven from the holding registers, stable for the whole state.
  - mem_ready=0: stay in BUSY (unbounded wait).
  - mem_ready=1: for a read, capture mem_rdata into core_rdata or host_rdata per owner; go to DONE.
  - Writes leave both rdata registers unchanged.
- DONE (exactly one cycle):
  - mem_req=0.
  - If owner=host: host_ack=1.
  - Then go to IDLE. Requests still high in IDLE are treated as new requests.
- core_stall (combinational) = core_req AND NOT (state==DONE AND owner==core).
  - Core stalls in IDLE and BUSY, and while the host owns the port.
  - Stall drops exactly in the DONE cycle, when core_rdata is already valid.
- host_ack=1 only in DONE with owner=host; never otherwise.
- Minimum transaction is 3 cycles (IDLE grant, BUSY with mem_ready=1, DONE). Each extra wait state adds 1 cycle.
- Requests arriving while in BUSY or DONE are not sampled until the next IDLE.
- Port data inputs may change freely outside the grant cycle; only the grant-cycle values are used.
- mem_ready high outside BUSY is ignored and has no effect on any register.
- core_rdata and host_rdata hold their last read value indefinitely.
- core_req deasserted at grant time: no core access is issued (grant is by sampled request only).

Test Plan:
- Reset, then core load addr 0x0010 with mem_ready tied 1 and memory returning 0xBEEF → mem_req high in cycle 2 with mem_addr=0x0010 and mem_we=0; core_stall=1 in cycles 1-2 and 0 in cycle 3; core_rdata=0xBEEF in cycle 3.
- Core store addr 0x0020, data 0x1234, with mem_ready low for 3 cycles then high → mem_req held 4 cycles with mem_we=1 and constant mem_addr/mem_wdata; core_stall low only in DONE; core_rdata unchanged.
- Core and host both request in the first cycle after reset → core granted first; host granted in the next IDLE; host_ack pulses exactly one cycle. A second simultaneous pair is granted core then host again, confirming alternation.
- Host read loop of 4 consecutive addresses while core_req=0 → 4 host_ack pulses spaced 3 cycles apart; host_rdata matches each memory word.
- Rst asserted during BUSY with mem_ready=0 → next cycle mem_req=0, state IDLE, host_ack=0, rdata registers=0; a later mem_ready pulse while idle changes nothing.
- mem_ready pulsed high during IDLE with no requests → no ack, no stall change, rdata registers unchanged.

Source files
------------

// File: rtl/dm_arbiter.sv
// Data-memory port arbiter: shares one req/ready memory port between the stack core and a host port.
// Each access is granted in IDLE, held in BUSY until mem_ready, and retired in a one-cycle DONE.
module dm_arbiter #(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter bit          RR_INIT = 1'b1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   owner;
    logic   last_owner;
    logic   grant;
    logic   grant_host;

    // Next-state and round-robin grant decision
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_host = 1'b0;
        case (state)
            IDLE: begin
                if (core_req || host_req) begin
                    grant      = 1'b1;
                    grant_host = host_req && (!core_req || (last_owner == OWNER_CORE));
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, holding registers and registered outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            owner      <= OWNER_CORE;
            last_owner <= RR_INIT;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rdata <= '0;
            host_rdata <= '0;
            host_ack   <= 1'b0;
        end else begin
            state    <= state_next;
            mem_req  <= (state_next == BUSY);
            host_ack <= (state == BUSY) && mem_ready && (owner == OWNER_HOST);
            if (grant) begin
                owner      <= grant_host;
                last_owner <= grant_host;
                mem_we     <= grant_host ? host_we    : core_we;
                mem_addr   <= grant_host ? host_addr  : core_addr;
                mem_wdata  <= grant_host ? host_wdata : core_wdata;
            end else if (state_next != BUSY) begin
                mem_we <= 1'b0;
            end
            // Only reads update the owner's read-data register
            if ((state == BUSY) && mem_ready && !mem_we) begin
                if (owner == OWNER_HOST) begin
                    host_rdata <= mem_rdata;
                end else begin
                    core_rdata <= mem_rdata;
                end
            end
        end
    end

    assign core_stall = core_req && !((state == DONE) && (owner == OWNER_CORE));

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: cycle vector table, directed corner sequences,
// then random core/host traffic checked against a transaction-level memory model.
module tb_dm_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [15:0] core_addr = '0, core_wdata = '0, core_rdata;
    logic        core_stall;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [15:0] host_addr = '0, host_wdata = '0, host_rdata;
    logic        host_ack;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    dm_arbiter #(.AW(16), .DW(16), .RR_INIT(1'b1)) dut (
        .Clk(Clk), .Rst(Rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 Clk = ~Clk;

    // Power-up contents of the memory; 0x10 holds 0xBEEF for the first load
    function automatic logic [15:0] init_word(input logic [7:0] a);
        if (a == 8'h10) return 16'hBEEF;
        return {a, a} ^ 16'h5A3C;
    endfunction

    // Memory behind the arbiter: written only when a write handshake completes
    bit [15:0]  mem_arr [256];
    bit [255:0] mem_wr;
    assign mem_rdata = mem_wr[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]] : init_word(mem_addr[7:0]);
    always @(posedge Clk) begin
        if (mem_req && mem_ready && mem_we) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata;
            mem_wr[mem_addr[7:0]]  <= 1'b1;
        end
    end

    // Reference memory contents seen by completed transactions
    bit [15:0]  mdl_val [256];
    bit [255:0] mdl_wr;
    function automatic logic [15:0] mdl_read(input logic [7:0] a);
        return mdl_wr[a] ? mdl_val[a] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        creq;
        logic        cwe;
        logic [15:0] caddr;
        logic [15:0] cwd;
        logic        hreq;
        logic [15:0] haddr;
        logic        rdy;
        logic        emreq;
        logic        emwe;
        logic [15:0] emaddr;
        logic [15:0] emwd;
        logic        estall;
        logic        eack;
        logic [15:0] ecrd;
        logic [15:0] ehrd;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    initial begin
        int acks;
        int last;
        bit c_pend, c_we, h_pend, h_we;
        logic [15:0] c_addr, c_wd, h_addr, h_wd;
        int c_wait, h_wait, must_next;
        bit match;

        //        rst   creq  cwe   caddr     cwd       hreq  haddr     rdy  | mreq  mwe   maddr     mwd       stall eack  crd       hrd
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b0, 16'hBEEF, 16'h0000};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b0, 16'hBEEF, 16'h0000};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b0, 16'hBEEF, 16'h0000};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b0, 16'hBEEF, 16'h0000};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h0000};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h0000};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h0000};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'hBEEF};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'hBEEF};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0020, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'hBEEF};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'hBEEF};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'hBEEF};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0020, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'hBEEF};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 16'h1234};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h1234};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h1234};

        // Reset state
        @(posedge Clk); @(posedge Clk); @(negedge Clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_host_ack", 32'(host_ack), 32'd0);
        chk("rst_core_rdata", 32'(core_rdata), 32'd0);
        chk("rst_host_rdata", 32'(host_rdata), 32'd0);

        // Cycle-by-cycle vector table
        for (int i = 0; i < NV; i++) begin
            @(posedge Clk); #1;
            Rst = vecs[i].rst;       core_req = vecs[i].creq;  core_we = vecs[i].cwe;
            core_addr = vecs[i].caddr; core_wdata = vecs[i].cwd;
            host_req = vecs[i].hreq; host_we = 1'b0; host_addr = vecs[i].haddr; host_wdata = '0;
            mem_ready = vecs[i].rdy;
            @(negedge Clk);
            chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].emreq));
            chk($sformatf("v%0d_stall", i), 32'(core_stall), 32'(vecs[i].estall));
            chk($sformatf("v%0d_ack", i), 32'(host_ack), 32'(vecs[i].eack));
            chk($sformatf("v%0d_core_rdata", i), 32'(core_rdata), 32'(vecs[i].ecrd));
            chk($sformatf("v%0d_host_rdata", i), 32'(host_rdata), 32'(vecs[i].ehrd));
            if (vecs[i].emreq) begin
                chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].emwe));
                chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].emaddr));
                chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].emwd));
            end
        end

        // Host read loop over 4 addresses: acks spaced 3 cycles
        acks = 0; last = 0;
        @(posedge Clk); #1;
        core_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0030; mem_ready = 1'b1;
        for (int c = 1; c <= 40 && acks < 4; c++) begin
            @(negedge Clk);
            if (host_ack) begin
                chk("hloop_rdata", 32'(host_rdata), 32'(init_word(8'(host_addr))));
                if (acks > 0) chk("hloop_gap", 32'(c - last), 32'd3);
                last = c;
                acks++;
            end
            @(posedge Clk); #1;
            host_addr = 16'(16'h0030 + 16'(acks));
            if (acks == 4) host_req = 1'b0;
        end
        chk("hloop_count", 32'(acks), 32'd4);

        // Reset while BUSY with mem_ready low
        host_req = 1'b1; host_addr = 16'h0040; mem_ready = 1'b0;
        @(negedge Clk);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("rbusy_mem_req", 32'(mem_req), 32'd1);
        @(posedge Clk); #1; Rst = 1'b1;
        @(posedge Clk); #1; Rst = 1'b0; host_req = 1'b0;
        @(negedge Clk);
        chk("rbusy_after_req", 32'(mem_req), 32'd0);
        chk("rbusy_after_ack", 32'(host_ack), 32'd0);
        chk("rbusy_after_crd", 32'(core_rdata), 32'd0);
        chk("rbusy_after_hrd", 32'(host_rdata), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk); #1; mem_ready = 1'b1;
            @(negedge Clk);
            chk("idle_rdy_req", 32'(mem_req), 32'd0);
            chk("idle_rdy_ack", 32'(host_ack), 32'd0);
            chk("idle_rdy_stall", 32'(core_stall), 32'd0);
            chk("idle_rdy_rdata", {core_rdata, host_rdata}, 32'd0);
        end
        // Arbiter is back in IDLE: a core load retires in the minimum 3 cycles
        @(posedge Clk); #1; core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0010;
        @(negedge Clk); chk("post_rst_c1_stall", 32'(core_stall), 32'd1);
        @(posedge Clk); #1;
        @(negedge Clk); chk("post_rst_c2_req", 32'(mem_req), 32'd1);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("post_rst_c3_stall", 32'(core_stall), 32'd0);
        chk("post_rst_c3_rdata", 32'(core_rdata), 32'hBEEF);
        @(posedge Clk); #1; core_req = 1'b0;

        // Random traffic against the transaction-level model
        c_pend = 0; h_pend = 0; c_wait = 0; h_wait = 0; must_next = 0;
        c_we = 0; h_we = 0; c_addr = '0; h_addr = '0; c_wd = '0; h_wd = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge Clk); #1;
            mem_ready = ($urandom_range(0, 3) != 0);
            if (!c_pend) begin
                c_we = 1'($urandom_range(0, 1)); c_addr = 16'($urandom_range(0, 15)); c_wd = 16'($urandom);
                c_pend = ($urandom_range(0, 2) == 0);
                core_req = c_pend; core_we = c_we; core_addr = c_addr; core_wdata = c_wd;
                c_wait = 0;
            end
            if (!h_pend) begin
                h_we = 1'($urandom_range(0, 1)); h_addr = 16'($urandom_range(0, 15)); h_wd = 16'($urandom);
                h_pend = ($urandom_range(0, 2) == 0);
                host_req = h_pend; host_we = h_we; host_addr = h_addr; host_wdata = h_wd;
                h_wait = 0;
            end
            @(negedge Clk);
            if (mem_req) begin
                match = (c_pend && mem_addr == c_addr && mem_we == c_we && (!c_we || mem_wdata == c_wd)) ||
                        (h_pend && mem_addr == h_addr && mem_we == h_we && (!h_we || mem_wdata == h_wd));
                chk("rnd_mem_cmd", 32'(match), 32'd1);
            end
            if (c_pend && !core_stall) begin
                if (must_next != 0) chk("rnd_rr_core", 32'(must_next), 32'd1);
                if (c_we) begin
                    mdl_val[c_addr[7:0]] = c_wd; mdl_wr[c_addr[7:0]] = 1'b1;
                end else begin
                    chk("rnd_core_rdata", 32'(core_rdata), 32'(mdl_read(c_addr[7:0])));
                end
                must_next = h_pend ? 2 : 0;
                c_pend = 0;
            end
            if (host_ack) begin
                chk("rnd_ack_pending", 32'(h_pend), 32'd1);
                if (h_pend) begin
                    if (must_next != 0) chk("rnd_rr_host", 32'(must_next), 32'd2);
                    if (h_we) begin
                        mdl_val[h_addr[7:0]] = h_wd; mdl_wr[h_addr[7:0]] = 1'b1;
                    end else begin
                        chk("rnd_host_rdata", 32'(host_rdata), 32'(mdl_read(h_addr[7:0])));
                    end
                    must_next = c_pend ? 1 : 0;
                    h_pend = 0;
                end
            end
            if (c_pend) c_wait++;
            if (h_pend) h_wait++;
            if (c_wait > 200 || h_wait > 200) begin
                chk("rnd_timeout", 32'(c_wait > 200 || h_wait > 200), 32'd0);
                c_pend = 0; h_pend = 0; c_wait = 0; h_wait = 0; must_next = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
